// File: rtl/snoopy_sprite_drawer_if.sv
// snoopy_sprite_drawer_if: redraw request from the game FSMs and the pixel-plot stream to the VGA adapter.
interface snoopy_sprite_drawer_if;
    logic       frame_tick;
    logic [6:0] snoopy_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;
    modport master (
        output frame_tick, snoopy_y,
        input  vga_x, vga_y, vga_colour, plot, busy, done
    );
    modport slave (
        input  frame_tick, snoopy_y,
        output vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/snoopy_sprite_drawer.sv
// snoopy_sprite_drawer: once per frame erases Snoopy at the old row and redraws him at the new one,
// emitting one pixel per cycle to the 160x120 VGA adapter.
module snoopy_sprite_drawer #(
    parameter int                           SNOOPY_X      = 20,
    parameter int                           SPRITE_W      = 8,
    parameter int                           SPRITE_H      = 8,
    parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK   = '1,
    parameter logic [2:0]                   SNOOPY_COLOUR = 3'b111,
    parameter logic [2:0]                   BG_COLOUR     = 3'b000,
    parameter int                           MAX_Y         = 119
) (
    input logic                   clock,
    input logic                   reset,
    snoopy_sprite_drawer_if.slave bus
);
    localparam int IW = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1;
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
    state_t     state;
    logic [3:0] px, py;
    logic [6:0] new_y, prev_y;
    logic       drawn;
    logic       active, last_px, last_py, visible;
    logic [7:0] row;
    logic [IW-1:0] idx;
    assign active  = (state == ERASE) || (state == DRAW);
    assign last_px = px == 4'(SPRITE_W - 1);
    assign last_py = py == 4'(SPRITE_H - 1);
    // Row sum kept 8 bits wide so sprites hanging off the bottom clip instead of wrapping to the top.
    assign row     = {1'b0, (state == ERASE) ? prev_y : new_y} + {4'b0, py};
    assign visible = row <= 8'(MAX_Y);
    assign idx     = IW'(int'(py) * SPRITE_W + int'(px));
    assign bus.vga_x      = active ? 8'(SNOOPY_X) + {4'b0, px} : '0;
    assign bus.vga_y      = active ? row[6:0] : '0;
    assign bus.vga_colour = (state == ERASE) ? BG_COLOUR : (state == DRAW) ? SNOOPY_COLOUR : '0;
    // Erase wipes the whole box; draw honours the mask.
    assign bus.plot       = active && visible && ((state == ERASE) || SPRITE_MASK[idx]);
    assign bus.busy       = active;
    assign bus.done       = state == DONE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            px     <= '0;
            py     <= '0;
            new_y  <= '0;
            prev_y <= '0;
            drawn  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.frame_tick) begin
                    new_y <= bus.snoopy_y;
                    px    <= '0;
                    py    <= '0;
                    state <= !drawn ? DRAW : (bus.snoopy_y == prev_y) ? DONE : ERASE;
                end
                ERASE, DRAW: begin
                    px <= last_px ? '0 : px + 4'd1;
                    if (last_px) py <= last_py ? '0 : py + 4'd1;
                    if (last_px && last_py) state <= (state == ERASE) ? DRAW : DONE;
                end
                DONE: begin
                    prev_y <= new_y;
                    drawn  <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoopy_sprite_drawer.sv
// tb_snoopy_sprite_drawer: directed frames against the 8x8 sprite with mask bit 0 transparent.
module tb_snoopy_sprite_drawer;
    localparam logic [63:0] MASK = ~64'h1;
    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    snoopy_sprite_drawer_if bus ();
    snoopy_sprite_drawer #(.SPRITE_MASK(MASK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );
    always #5 clock = ~clock;

    // Runs one frame: passes = 0 (unchanged y), 1 (draw only) or 2 (erase at eb, then draw at y).
    task automatic capture(input int y, input int eb, input int passes, input int tick_at, input int tick_y,
                           output int plots, output int busy_n, output int done_k, output int mism);
        int  i, base, row;
        bit  er;
        logic exp_plot;
        plots = 0; busy_n = 0; done_k = -1; mism = 0;
        bus.frame_tick = 1'b1;
        bus.snoopy_y   = 7'(y);
        @(posedge clock); #1;
        bus.frame_tick = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            plots  += int'(bus.plot);
            busy_n += int'(bus.busy);
            i = k - 1;
            if (i < passes * 64) begin
                er   = (passes == 2) && (i < 64);
                base = er ? eb : y;
                i    = i % 64;
                row  = base + i / 8;
                exp_plot = (row <= 119) && (er || MASK[i]);
                if (bus.plot !== exp_plot || bus.vga_x !== 8'(20 + i % 8) || bus.vga_y !== 7'(row) ||
                    bus.vga_colour !== (er ? 3'd0 : 3'd7) || bus.busy !== 1'b1 || bus.done !== 1'b0)
                    mism++;
            end else if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.plot !== 1'b0) begin
                mism++;
            end
            if (bus.done === 1'b1 && done_k < 0) done_k = k;
            if (k == tick_at) begin
                bus.frame_tick = 1'b1;
                bus.snoopy_y   = 7'(tick_y);
            end
            @(posedge clock); #1;
            bus.frame_tick = 1'b0;
            if (done_k > 0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.snoopy_y = '0;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0) begin
            fails++; $display("FAIL reset_xyc got %h required 0", {bus.vga_x, bus.vga_y, bus.vga_colour});
        end
        tests++;
        if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got %b required 000", {bus.plot, bus.busy, bus.done});
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_frame(input string name, input int y, input int eb, input int passes,
                              input int tick_at, input int tick_y, input int exp_plots);
        int plots, busy_n, done_k, mism;
        capture(y, eb, passes, tick_at, tick_y, plots, busy_n, done_k, mism);
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL %s pixels got %0d bad cycles required 0", name, mism); end
        tests++;
        if (plots !== exp_plots) begin fails++; $display("FAIL %s plots got %0d required %0d", name, plots, exp_plots); end
        tests++;
        if (busy_n !== passes * 64) begin fails++; $display("FAIL %s busy got %0d required %0d", name, busy_n, passes * 64); end
        tests++;
        if (done_k !== passes * 64 + 1) begin fails++; $display("FAIL %s done_cycle got %0d required %0d", name, done_k, passes * 64 + 1); end
    endtask

    task automatic check_idle(input string name);
        int bad = 0;
        repeat (3) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.plot !== 1'b0) bad++;
            @(posedge clock); #1;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL %s idle got %0d active cycles required 0", name, bad); end
    endtask

    task automatic test_first_draw();
        test_frame("first_draw", 100, -1, 1, 0, 0, 63);
        tests++;
        if (bus.done !== 1'b0) begin fails++; $display("FAIL done_width got %b required 0", bus.done); end
    endtask

    task automatic test_erase_draw();
        test_frame("erase_draw", 95, 100, 2, 0, 0, 127);
    endtask

    task automatic test_unchanged();
        test_frame("unchanged", 95, -1, 0, 0, 0, 0);
        check_idle("unchanged");
    endtask

    task automatic test_clip();
        test_frame("clip_bottom", 115, 95, 2, 0, 0, 103);
        test_frame("clip_no_wrap", 125, 115, 2, 0, 0, 40);
    endtask

    task automatic test_ticks_ignored();
        test_frame("tick_busy", 50, 125, 2, 10, 60, 63);
        check_idle("tick_busy");
        test_frame("tick_done", 50, -1, 0, 1, 70, 0);
        check_idle("tick_done");
        test_frame("prev_kept", 50, -1, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_draw();
        bus.frame_tick = 1'b1;
        bus.snoopy_y = 7'd30;
        @(posedge clock); #1;
        bus.frame_tick = 1'b0;
        repeat (94) @(posedge clock);
        #1;
        tests++;
        if ({bus.plot, bus.vga_x, bus.vga_y} !== {1'b1, 8'd26, 7'd33}) begin
            fails++; $display("FAIL mid_draw_pixel got %b/%0d/%0d required 1/26/33", bus.plot, bus.vga_x, bus.vga_y);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        tests++;
        if ({bus.plot, bus.busy, bus.done, bus.vga_x, bus.vga_y, bus.vga_colour} !== 21'd0) begin
            fails++; $display("FAIL mid_reset_outputs got %h required 0",
                              {bus.plot, bus.busy, bus.done, bus.vga_x, bus.vga_y, bus.vga_colour});
        end
        reset = 1'b0;
        test_frame("after_reset", 100, -1, 1, 0, 0, 63);
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_erase_draw();
        test_unchanged();
        test_clip();
        test_ticks_ignored();
        test_reset_mid_draw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
